// File: rtl/ibex_pkg.sv
// Shared types for the instruction-fetch responder: response metadata carried
// alongside the SRAM read, plus the supported read-latency ceiling.
package ibex_pkg;

   typedef struct packed {
      logic valid;
      logic err;
   } instr_resp_meta_t;

   localparam int unsigned IBEX_INSTR_RESP_MAX_LAT = 4;

endpackage

// File: rtl/ibex_instr_mem_resp_pipe.sv
// Delay line of response metadata, Depth cycles, no stall (the fetch bus has no rvalid back-pressure).
// Only the valid bits are reset; err bits are don't-care whenever their valid is low.
module ibex_instr_mem_resp_pipe
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  instr_resp_meta_t in_meta,
   output instr_resp_meta_t out_meta
);

   logic [Depth-1:0] valid_q;
   logic [Depth-1:0] err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= in_meta.valid;
         for (int i = 1; i < Depth; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      err_q[0] <= in_meta.err;
      for (int i = 1; i < Depth; i++) begin
         err_q[i] <= err_q[i-1];
      end
   end

   assign out_meta.valid = valid_q[Depth-1];
   assign out_meta.err   = err_q[Depth-1];

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Fetch-bus responder over a fixed-latency SRAM: rvalid exactly RamLatency cycles after gnt, in order.
// No rvalid back-pressure; grants are withheld once MaxOutstanding requests are in flight.
module ibex_instr_mem_responder
   import ibex_pkg::*;
#(
   parameter int unsigned MemDepthWords  = 4096,
   parameter logic [31:0] BaseAddr       = 32'h0,
   parameter int unsigned RamLatency     = 1,
   parameter int unsigned MaxOutstanding = 2,
   localparam int unsigned AW            = $clog2(MemDepthWords)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          instr_req_i,
   input  logic [31:0]   instr_addr_i,
   output logic          instr_gnt_o,
   output logic          instr_rvalid_o,
   output logic [31:0]   instr_rdata_o,
   output logic          instr_err_o,
   input  logic          gnt_stall_i,
   output logic          ram_req_o,
   output logic [AW-1:0] ram_addr_o,
   input  logic [31:0]   ram_rdata_i
);

   localparam logic [32:0] MEM_BYTES = 33'(MemDepthWords) << 2;

   if (RamLatency < 1 || RamLatency > IBEX_INSTR_RESP_MAX_LAT) begin : g_bad_latency
      $error("RamLatency out of supported range");
   end

   logic [33:0]      ofs;
   logic             req_err;
   logic [2:0]       outstanding_q;
   instr_resp_meta_t meta_in;
   instr_resp_meta_t meta_out;

   // Borrow out of the 34-bit subtraction flags an address below BaseAddr;
   // no 32-bit wrap can alias a high address back into range.
   assign ofs     = {2'b00, instr_addr_i} - {2'b00, BaseAddr};
   assign req_err = (|ofs[1:0]) | ofs[33] | (ofs[32:0] >= MEM_BYTES);

   assign instr_gnt_o = instr_req_i & ~gnt_stall_i &
                        ((outstanding_q < 3'(MaxOutstanding)) | instr_rvalid_o);

   assign ram_req_o  = instr_gnt_o & ~req_err;
   assign ram_addr_o = ofs[AW+1:2];

   assign meta_in.valid = instr_gnt_o;
   assign meta_in.err   = req_err;

   ibex_instr_mem_resp_pipe #(
      .Depth (RamLatency)
   ) u_resp_pipe (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .in_meta  (meta_in),
      .out_meta (meta_out)
   );

   assign instr_rvalid_o = meta_out.valid;
   assign instr_err_o    = meta_out.valid & meta_out.err;
   assign instr_rdata_o  = (meta_out.valid & ~meta_out.err) ? ram_rdata_i : 32'h0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstanding_q <= 3'd0;
      end else begin
         case ({instr_gnt_o, instr_rvalid_o})
            2'b10:   outstanding_q <= outstanding_q + 3'd1;
            2'b01:   outstanding_q <= outstanding_q - 3'd1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   a_outstanding_max : assert property (@(posedge clk_i) disable iff (rst_i)
      outstanding_q <= 3'(MaxOutstanding));
   a_outstanding_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(instr_rvalid_o && outstanding_q == 3'd0));

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench: one responder with default parameters and one with RamLatency=3, MaxOutstanding=2.
module tb_ibex_instr_mem_responder;

   logic clk;
   logic rst;

   logic        req_a, stall_a, gnt_a, rvalid_a, err_a, ram_req_a;
   logic [31:0] addr_a, rdata_a, ram_rdata_a;
   logic [11:0] ram_addr_a;

   logic        req_b, stall_b, gnt_b, rvalid_b, err_b, ram_req_b;
   logic [31:0] addr_b, rdata_b;
   logic [11:0] ram_addr_b;
   logic [31:0] pb0, pb1, pb2;

   logic [31:0] mem [4096];

   int n_cmp = 0;
   int n_bad = 0;

   ibex_instr_mem_responder u_dut_a (
      .clk_i          (clk),
      .rst_i          (rst),
      .instr_req_i    (req_a),
      .instr_addr_i   (addr_a),
      .instr_gnt_o    (gnt_a),
      .instr_rvalid_o (rvalid_a),
      .instr_rdata_o  (rdata_a),
      .instr_err_o    (err_a),
      .gnt_stall_i    (stall_a),
      .ram_req_o      (ram_req_a),
      .ram_addr_o     (ram_addr_a),
      .ram_rdata_i    (ram_rdata_a)
   );

   ibex_instr_mem_responder #(
      .RamLatency     (3),
      .MaxOutstanding (2)
   ) u_dut_b (
      .clk_i          (clk),
      .rst_i          (rst),
      .instr_req_i    (req_b),
      .instr_addr_i   (addr_b),
      .instr_gnt_o    (gnt_b),
      .instr_rvalid_o (rvalid_b),
      .instr_rdata_o  (rdata_b),
      .instr_err_o    (err_b),
      .gnt_stall_i    (stall_b),
      .ram_req_o      (ram_req_b),
      .ram_addr_o     (ram_addr_b),
      .ram_rdata_i    (pb2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM models; unrequested reads return a poison word.
   always @(posedge clk) begin
      ram_rdata_a <= ram_req_a ? mem[ram_addr_a] : 32'hDEAD_BEEF;
      pb0 <= ram_req_b ? mem[ram_addr_b] : 32'hDEAD_BEEF;
      pb1 <= pb0;
      pb2 <= pb1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        stall;
      logic        gnt;
      logic        ram_req;
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vt [14];

   int exp_g   [12] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
   int exp_rv  [12] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
   int exp_cnt [12] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 1, 0};

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int ngr;
      int nrv;

      for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;

      //           req   addr          stall gnt  rreq rvld err  rdata
      vt[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[1]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0000};
      vt[2]  = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0001};
      vt[3]  = '{1'b1, 32'h0000_000C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0002};
      vt[4]  = '{1'b1, 32'h0000_4000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0003};
      vt[5]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
      vt[6]  = '{1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0004};
      vt[7]  = '{1'b1, 32'h0000_3FFC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
      vt[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0FFF};
      vt[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
      vt[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      vt[11] = '{1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      vt[12] = '{1'b1, 32'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0008};

      rst = 1'b1;
      req_a = 1'b0; addr_a = '0; stall_a = 1'b0;
      req_b = 1'b0; addr_b = '0; stall_b = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst.gnt_a", 32'(gnt_a), 32'h0);
      chk("rst.rvalid_a", 32'(rvalid_a), 32'h0);
      chk("rst.rdata_a", rdata_a, 32'h0);
      chk("rst.err_a", 32'(err_a), 32'h0);
      chk("rst.ram_req_a", 32'(ram_req_a), 32'h0);
      chk("rst.rvalid_b", 32'(rvalid_b), 32'h0);
      chk("rst.cnt_b", 32'(u_dut_b.outstanding_q), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Table: default-parameter responder, streaming fetches with errors and stall
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         req_a = vt[i].req; addr_a = vt[i].addr; stall_a = vt[i].stall;
         #1;
         chk($sformatf("v%0d.gnt", i),     32'(gnt_a),     32'(vt[i].gnt));
         chk($sformatf("v%0d.ram_req", i), 32'(ram_req_a), 32'(vt[i].ram_req));
         chk($sformatf("v%0d.rvalid", i),  32'(rvalid_a),  32'(vt[i].rvalid));
         chk($sformatf("v%0d.err", i),     32'(err_a),     32'(vt[i].err));
         chk($sformatf("v%0d.rdata", i),   rdata_a,        vt[i].rdata);
      end

      // Latency 3, two outstanding: grant throttling and same-cycle retire/grant
      ngr = 0;
      nrv = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         req_b  = (c < 9);
         addr_b = 32'(4 * ngr);
         #1;
         chk($sformatf("thr%0d.gnt", c), 32'(gnt_b), 32'(exp_g[c]));
         chk($sformatf("thr%0d.rvalid", c), 32'(rvalid_b), 32'(exp_rv[c]));
         chk($sformatf("thr%0d.cnt", c), 32'(u_dut_b.outstanding_q), 32'(exp_cnt[c]));
         if (exp_rv[c] != 0) begin
            chk($sformatf("thr%0d.rdata", c), rdata_b, 32'h1000_0000 + 32'(nrv));
            chk($sformatf("thr%0d.err", c), 32'(err_b), 32'h0);
            nrv++;
         end
         if (exp_g[c] != 0) ngr++;
      end
      req_b = 1'b0;

      // Stall blocks new grants while an earlier grant still answers on time
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         req_b   = (c < 6);
         stall_b = (c >= 1 && c <= 5);
         addr_b  = (c == 0) ? 32'h40 : 32'h44;
         #1;
         chk($sformatf("stl%0d.gnt", c), 32'(gnt_b), (c == 0) ? 32'h1 : 32'h0);
         chk($sformatf("stl%0d.ram_req", c), 32'(ram_req_b), (c == 0) ? 32'h1 : 32'h0);
         chk($sformatf("stl%0d.rvalid", c), 32'(rvalid_b), (c == 3) ? 32'h1 : 32'h0);
         if (c == 3) chk("stl3.rdata", rdata_b, 32'h1000_0010);
      end
      req_b = 1'b0; stall_b = 1'b0;

      // Reset with two requests in flight
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         req_b = 1'b1; addr_b = 32'(4 * c);
         #1;
         chk($sformatf("rsq%0d.gnt", c), 32'(gnt_b), 32'h1);
      end
      @(negedge clk);
      req_b = 1'b0;
      rst = 1'b1;
      #1;
      chk("rsq.cnt_in_rst", 32'(u_dut_b.outstanding_q), 32'h0);
      chk("rsq.rvalid_in_rst", 32'(rvalid_b), 32'h0);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rsq.post%0d.rvalid", c), 32'(rvalid_b), 32'h0);
      end
      @(negedge clk);
      req_b = 1'b1; addr_b = 32'h8;
      #1;
      chk("rsq.regrant.gnt", 32'(gnt_b), 32'h1);
      for (int c = 1; c < 5; c++) begin
         @(negedge clk);
         req_b = 1'b0;
         #1;
         chk($sformatf("rsq.resp%0d.rvalid", c), 32'(rvalid_b), (c == 3) ? 32'h1 : 32'h0);
         if (c == 3) chk("rsq.resp.rdata", rdata_b, 32'h1000_0002);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
